hazard_sequencer: RTL

- Pipeline sequencing block for the five-stage core (IF, ID, EX, MEM, WB).
- Sits beside the control unit and consumes the ID-stage control word (target select result, RF_LE, L, ID_SR, B/UB).
- Keeps a shadow scoreboard of in-flight writers and drives stall, bubble and flush controls for the pipeline registers, plus operand-forwarding selects.
- Counts stall cycles for performance monitoring.

---
 rtl/hazard_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: load-use stall, branch flush and operand-forwarding control
// for the five-stage pipeline. A shadow copy of the EX/MEM/WB writer fields is
// kept here so hazards are resolved from the ID-stage control word alone.

// Runtime checks on the sequencer's internal consistency.
module hazard_sequencer_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic load_use_i,
    input  logic branch_i,
    input  logic stall_state_i
);

    // A taken branch sits in EX, so EX cannot also be a load feeding ID.
    a_no_branch_with_load_use: assert property (
        @(posedge clk) disable iff (!rst_n) !(load_use_i && branch_i)
    ) else $error("load-use hazard coincides with a taken branch in EX");

    // The stall lasts exactly one cycle: STALL is always followed by RUN.
    a_stall_one_cycle: assert property (
        @(posedge clk) disable iff (!rst_n) stall_state_i |=> !stall_state_i
    ) else $error("sequencer stayed in STALL for more than one cycle");

    // While stalled EX holds a bubble, so no new load-use can be seen.
    a_no_load_use_in_stall: assert property (
        @(posedge clk) disable iff (!rst_n) !(stall_state_i && load_use_i)
    ) else $error("load-use hazard detected while already stalled");

endmodule

module hazard_sequencer #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic [1:0]        id_sr,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rf_le,
    input  logic              id_load,
    input  logic              ex_branch_taken,
    output logic              pc_le,
    output logic              ifid_le,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              state_o
);

    // Writer information tracked for each in-flight stage.
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
    } stage_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [REG_AW-1:0] REG_ZERO    = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam stage_t            STAGE_EMPTY = '{v: 1'b0, rd: REG_ZERO, wr: 1'b0, ld: 1'b0};

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // A stage really writes the register file only when valid, enabled and
    // not targeting the hardwired-zero register.
    function automatic logic is_writer(input stage_t s);
        return s.v & s.wr & (s.rd != REG_ZERO);
    endfunction

    // Youngest matching writer wins; an EX load cannot forward (its data is
    // not ready yet), that case is covered by the one-cycle stall.
    function automatic logic [1:0] fwd_select(
        input logic              use_src,
        input logic [REG_AW-1:0] src,
        input stage_t            ex_s,
        input stage_t            mem_s,
        input stage_t            wb_s
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (!use_src || (src == REG_ZERO)) begin
            sel = SEL_RF;
        end else if (is_writer(ex_s) && !ex_s.ld && (ex_s.rd == src)) begin
            sel = SEL_EX;
        end else if (is_writer(mem_s) && (mem_s.rd == src)) begin
            sel = SEL_MEM;
        end else if (is_writer(wb_s) && (wb_s.rd == src)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    stage_t              ex_q;
    stage_t              ex_d;
    stage_t              mem_q;
    stage_t              wb_q;
    stage_t              id_stage_s;
    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                src_hit_s;
    logic                load_use_s;
    logic                stall_s;

    // Load-use detection against the shadow EX stage; a taken branch masks it.
    always_comb begin
        src_hit_s  = (id_sr[1] & (id_ra == ex_q.rd)) | (id_sr[0] & (id_rb == ex_q.rd));
        load_use_s = id_valid & ex_q.v & ex_q.ld & ex_q.wr & (ex_q.rd != REG_ZERO) & src_hit_s;
        stall_s    = load_use_s & ~ex_branch_taken;
    end

    // Next EX shadow entry: the ID instruction, or a bubble while stalling.
    always_comb begin
        id_stage_s.v  = id_valid;
        id_stage_s.rd = id_rd;
        id_stage_s.wr = id_rf_le;
        id_stage_s.ld = id_load;
        if (stall_s) begin
            ex_d = STAGE_EMPTY;
        end else begin
            ex_d = id_stage_s;
        end
    end

    // Shadow pipeline advance; the branch flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= STAGE_EMPTY;
            mem_q <= STAGE_EMPTY;
            wb_q  <= STAGE_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a stall lasts one cycle, after which the load is in MEM
    // and its result is forwarded from there.
    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN: begin
                if (stall_s) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STALL: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating stall-cycle counter next value.
    always_comb begin
        if (stall_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Pipeline controls and forwarding selects; flush is held low in reset.
    always_comb begin
        pc_le       = ~stall_s;
        ifid_le     = ~stall_s;
        idex_bubble = stall_s;
        ifid_flush  = ex_branch_taken & rst_n;
        fwd_a       = fwd_select(id_sr[1], id_ra, ex_q, mem_q, wb_q);
        fwd_b       = fwd_select(id_sr[0], id_rb, ex_q, mem_q, wb_q);
        state_o     = (state_q == ST_STALL);
        stall_cnt   = cnt_q;
    end

    hazard_sequencer_chk u_chk (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_use_i    (load_use_s),
        .branch_i      (ex_branch_taken),
        .stall_state_i (state_q == ST_STALL)
    );

endmodule
